// File: rtl/neuron_layer.sv
// Layer of N_NEURONS leaky integrate-and-fire neurons fed by a serial presynaptic spike stream.
// Define NEURON_LAYER_STDP_EN to add the LEARN state (simplified STDP on neurons that fired).
module neuron_layer #(
    parameter int unsigned N_INPUTS   = 784,
    parameter int unsigned N_NEURONS  = 4,
    parameter int unsigned W_WIDTH    = 8,
    parameter int unsigned V_WIDTH    = 16,
    parameter int          THRESH     = 100,
    parameter int unsigned LEAK_SHIFT = 3,
    parameter int unsigned REFRAC     = 2,
    localparam int unsigned NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    localparam int unsigned AW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_spike,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_NEURONS-1:0] out_spikes,
    input  logic                 wr_en,
    input  logic [NW-1:0]        wr_neuron,
    input  logic [AW-1:0]        wr_addr,
    input  logic [W_WIDTH-1:0]   wr_data,
    output logic                 wr_err,
    output logic                 busy
);

    localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int unsigned XW = V_WIDTH + 2;
    localparam logic [RW-1:0]              REFRAC_V = RW'(REFRAC);
    localparam logic [AW-1:0]              LAST_IDX = AW'(N_INPUTS - 1);
    localparam logic signed [V_WIDTH-1:0]  THR      = V_WIDTH'(THRESH);
    localparam logic signed [V_WIDTH-1:0]  VMAX     = {1'b0, {(V_WIDTH-1){1'b1}}};
    localparam logic signed [V_WIDTH-1:0]  VMIN     = {1'b1, {(V_WIDTH-1){1'b0}}};
    localparam logic signed [XW-1:0]       VMAX_X   = XW'(VMAX);
    localparam logic signed [XW-1:0]       VMIN_X   = XW'(VMIN);

`ifdef NEURON_LAYER_STDP_EN
    typedef enum logic [2:0] {S_IDLE, S_INTEGRATE, S_FIRE, S_LEARN, S_OUTPUT} state_t;
    localparam logic signed [W_WIDTH-1:0] WMAX = {1'b0, {(W_WIDTH-1){1'b1}}};
    localparam logic signed [W_WIDTH-1:0] WMIN = {1'b1, {(W_WIDTH-1){1'b0}}};
`else
    typedef enum logic [2:0] {S_IDLE, S_INTEGRATE, S_FIRE, S_OUTPUT} state_t;
`endif

    state_t state, state_nx;

    logic        [AW-1:0]      idx;
    logic signed [V_WIDTH-1:0] acc    [N_NEURONS];
    logic signed [V_WIDTH-1:0] v      [N_NEURONS];
    logic signed [V_WIDTH-1:0] vn     [N_NEURONS];
    logic        [RW-1:0]      refrac [N_NEURONS];
    logic signed [W_WIDTH-1:0] weight [N_NEURONS][N_INPUTS];
    logic [N_NEURONS-1:0]      spike_nx;
`ifdef NEURON_LAYER_STDP_EN
    logic [N_INPUTS-1:0]       pre;
`endif

    logic accept, last_beat, wr_ok;
    assign accept    = in_valid && in_ready;
    assign last_beat = (idx == LAST_IDX);
    assign wr_ok     = wr_en && (state == S_IDLE)
                       && (32'(wr_neuron) < N_NEURONS) && (32'(wr_addr) < N_INPUTS);

    function automatic logic signed [V_WIDTH-1:0] sat_v(input logic signed [XW-1:0] x);
        if (x > VMAX_X)      return VMAX;
        else if (x < VMIN_X) return VMIN;
        else                 return x[V_WIDTH-1:0];
    endfunction

    function automatic logic signed [V_WIDTH-1:0] acc_add(input logic signed [V_WIDTH-1:0] a,
                                                          input logic signed [W_WIDTH-1:0] w);
        return sat_v(XW'(a) + XW'(w));
    endfunction

`ifdef NEURON_LAYER_STDP_EN
    function automatic logic signed [W_WIDTH-1:0] w_step(input logic signed [W_WIDTH-1:0] w,
                                                         input logic up);
        if (up && (w != WMAX))       return w + W_WIDTH'(1);
        else if (!up && (w != WMIN)) return w - W_WIDTH'(1);
        else                         return w;
    endfunction
`endif

    // Leaky membrane update and threshold test, consumed in FIRE
    always_comb begin
        spike_nx = '0;
        for (int n = 0; n < int'(N_NEURONS); n++) begin
            vn[n] = sat_v(XW'(v[n]) - XW'(v[n] >>> LEAK_SHIFT) + XW'(acc[n]));
            spike_nx[n] = (refrac[n] == '0) && (vn[n] >= THR);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_INTEGRATE: if (accept) state_nx = last_beat ? S_FIRE : S_INTEGRATE;
`ifdef NEURON_LAYER_STDP_EN
            S_FIRE:   state_nx = (|spike_nx) ? S_LEARN : S_OUTPUT;
            S_LEARN:  if (last_beat) state_nx = S_OUTPUT;
`else
            S_FIRE:   state_nx = S_OUTPUT;
`endif
            S_OUTPUT: if (out_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_spikes <= '0;
            wr_err     <= 1'b0;
            busy       <= 1'b0;
            idx        <= '0;
            for (int n = 0; n < int'(N_NEURONS); n++) begin
                acc[n]    <= '0;
                v[n]      <= '0;
                refrac[n] <= '0;
            end
`ifdef NEURON_LAYER_STDP_EN
            pre <= '0;
`endif
        end else begin
            state     <= state_nx;
            in_ready  <= (state_nx == S_IDLE) || (state_nx == S_INTEGRATE);
            out_valid <= (state_nx == S_OUTPUT);
            busy      <= (state_nx != S_IDLE);
            wr_err    <= wr_en && !wr_ok;
            case (state)
                S_IDLE, S_INTEGRATE: if (accept) begin
                    for (int n = 0; n < int'(N_NEURONS); n++)
                        if (in_spike) acc[n] <= acc_add(acc[n], weight[n][idx]);
`ifdef NEURON_LAYER_STDP_EN
                    pre[idx] <= in_spike;
`endif
                    idx <= last_beat ? '0 : idx + AW'(1);
                end
                S_FIRE: begin
                    out_spikes <= spike_nx;
                    for (int n = 0; n < int'(N_NEURONS); n++) begin
                        acc[n] <= '0;
                        if (refrac[n] == '0) begin
                            v[n]      <= spike_nx[n] ? '0 : vn[n];
                            refrac[n] <= spike_nx[n] ? REFRAC_V : '0;
                        end else begin
                            v[n]      <= '0;
                            refrac[n] <= refrac[n] - RW'(1);
                        end
                    end
                end
`ifdef NEURON_LAYER_STDP_EN
                S_LEARN: idx <= last_beat ? '0 : idx + AW'(1);
`endif
                default: ;
            endcase
        end
    end

    // Weight store survives reset; host writes only land in IDLE
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            weight[wr_neuron][wr_addr] <= wr_data;
        end
`ifdef NEURON_LAYER_STDP_EN
        else if (state == S_LEARN) begin
            for (int n = 0; n < int'(N_NEURONS); n++)
                if (out_spikes[n]) weight[n][idx] <= w_step(weight[n][idx], pre[idx]);
        end
`endif
    end

endmodule
